// File: rtl/sfu_pkg.sv
// Shared definitions for the SFU issue/writeback controller.
// FSM encoding and default op-class configuration.
package sfu_pkg;

  localparam int OPW_DEF = 3;
  localparam logic [7:0] PIPE_OPS_DEF = 8'b0000_0011;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PIPE    = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_ITER    = 3'd3;
  localparam logic [2:0] S_ITER_WB = 3'd4;

endpackage

// File: rtl/sfu_lat_shreg.sv
// Stall-gated valid+sel delay line with occupancy count.
// A start landing in a stalled cycle waits in a one-entry hold slot.
module sfu_lat_shreg #(
  parameter int DEPTH = 4,
  parameter int W = 3,
  parameter int CW = $clog2(DEPTH + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          in_valid,
  input  logic [W-1:0]  in_sel,
  output logic          tail_valid,
  output logic [W-1:0]  tail_sel,
  output logic [CW-1:0] occ_nxt
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     sel [DEPTH];
  logic             hold_v;
  logic [W-1:0]     hold_sel;
  logic [CW-1:0]    occ;
  logic             pop;

  assign tail_valid = vld[DEPTH-1];
  assign tail_sel   = sel[DEPTH-1];
  assign pop        = tail_valid & ~stall;
  assign occ_nxt    = occ + CW'(in_valid) - CW'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld      <= '0;
      hold_v   <= 1'b0;
      hold_sel <= '0;
      occ      <= '0;
      for (int k = 0; k < DEPTH; k++) sel[k] <= '0;
    end else begin
      occ <= occ_nxt;
      if (!stall) begin
        vld[0] <= hold_v | in_valid;
        sel[0] <= hold_v ? hold_sel : in_sel;
        for (int k = 1; k < DEPTH; k++) begin
          vld[k] <= vld[k-1];
          sel[k] <= sel[k-1];
        end
        hold_v <= 1'b0;
      end else if (in_valid) begin
        hold_v   <= 1'b1;
        hold_sel <= in_sel;
      end
    end
  end

endmodule

// File: rtl/sfu_issue_ctrl.sv
// SFU issue/writeback controller: pipelined and iterative op classes.
// Optional perf counters under `SFU_ISSUE_PERF_EN.
module sfu_issue_ctrl
  import sfu_pkg::*;
#(
  parameter int LAT_PIPE = 4,
  parameter int LAT_ITER = 12,
  parameter int OPW = OPW_DEF,
  parameter logic [2**OPW-1:0] PIPE_OPS = PIPE_OPS_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           validi,
  input  logic [OPW-1:0] selop,
  output logic           re_i,
  output logic           start,
  output logic [OPW-1:0] op_sel,
  output logic           we,
  output logic [OPW-1:0] we_sel,
  output logic           busy,
  output logic [31:0]    perf_issued,
  output logic [31:0]    perf_stall
);

  localparam int IW = $clog2(LAT_ITER + 1);
  localparam int CW = $clog2(LAT_PIPE + 2);

  logic [2:0]     state, state_nxt;
  logic [IW-1:0]  iter_cnt;
  logic           cls;
  logic           pipe_in;
  logic           tail_valid;
  logic [OPW-1:0] tail_sel;
  logic [CW-1:0]  occ_nxt;
  logic           in_wb;

  assign cls     = PIPE_OPS[selop];
  assign pipe_in = start & PIPE_OPS[op_sel];
  assign in_wb   = (state == S_ITER_WB);

  sfu_lat_shreg #(
    .DEPTH (LAT_PIPE),
    .W     (OPW),
    .CW    (CW)
  ) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .in_valid   (pipe_in),
    .in_sel     (op_sel),
    .tail_valid (tail_valid),
    .tail_sel   (tail_sel),
    .occ_nxt    (occ_nxt)
  );

  always_comb begin
    re_i = 1'b0;
    case (state)
      S_IDLE:  re_i = validi & ~stall;
      S_PIPE:  re_i = validi & ~stall & cls;
      default: re_i = 1'b0;
    endcase
  end

  // occ_nxt already counts this cycle's start and pop
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (re_i) state_nxt = cls ? S_PIPE : S_ITER;
      end
      S_PIPE: begin
        if (!re_i) begin
          if (occ_nxt == '0)      state_nxt = S_IDLE;
          else if (validi & ~cls) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (occ_nxt == '0) state_nxt = S_IDLE;
      end
      S_ITER: begin
        if (iter_cnt == IW'(1)) state_nxt = S_ITER_WB;
      end
      S_ITER_WB: begin
        if (!stall) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      start    <= 1'b0;
      op_sel   <= '0;
      iter_cnt <= '0;
    end else begin
      state <= state_nxt;
      start <= re_i;
      if (re_i) op_sel <= selop;
      if (state == S_IDLE && re_i && !cls)
        iter_cnt <= IW'(LAT_ITER);
      else if (state == S_ITER)
        iter_cnt <= iter_cnt - IW'(1);
    end
  end

  assign we     = ~stall & (tail_valid | in_wb);
  assign we_sel = in_wb ? op_sel : tail_sel;
  assign busy   = (state != S_IDLE) | start;

`ifdef SFU_ISSUE_PERF_EN
  logic [31:0] issued_q, stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (start) issued_q <= issued_q + 32'd1;
      if (stall & (tail_valid | in_wb)) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`else
  assign perf_issued = 32'd0;
  assign perf_stall  = 32'd0;
`endif

endmodule
